// File: rtl/serial_compare_ctrl_if.sv
// serial_compare_ctrl_if: start/abort control, digit-pair stream and result bus.
interface serial_compare_ctrl_if #(parameter int DIGITS = 4);
    logic start;
    logic abort;
    logic valid;
    logic [1:0] digit_a;
    logic [1:0] digit_b;
    logic ready;
    logic busy;
    logic done;
    logic result_valid;
    logic gt;
    logic lt;
    logic eq;
    logic [$clog2(DIGITS+1)-1:0] count;
    modport master (
        output start, abort, valid, digit_a, digit_b,
        input  ready, busy, done, result_valid, gt, lt, eq, count
    );
    modport slave (
        input  start, abort, valid, digit_a, digit_b,
        output ready, busy, done, result_valid, gt, lt, eq, count
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: compares two operands streamed MSB-first as 2-bit digit pairs.
module serial_compare_ctrl #(
    parameter int DIGITS = 4
) (
    input logic clk,
    input logic rst,
    serial_compare_ctrl_if.slave s
);
    localparam int CW = $clog2(DIGITS + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] count;
    logic gt_f, lt_f, res_valid;
    logic accept, last, clear;
    always_comb begin
        accept  = state == RUN && s.valid && !s.abort;
        last    = count == CW'(DIGITS - 1);
        clear   = (state == IDLE && s.start) || (state != IDLE && s.abort);
        state_n = state == IDLE ? (s.start ? RUN : IDLE) :
                  state == RUN  ? (s.abort ? IDLE : (accept && last) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            gt_f      <= 1'b0;
            lt_f      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            state <= state_n;
            if (clear) begin
                count     <= '0;
                gt_f      <= 1'b0;
                lt_f      <= 1'b0;
                res_valid <= 1'b0;
            end else if (accept) begin
                count <= count + 1'b1;
                // only the first unequal pair decides; later pairs are counted but ignored
                if (!(gt_f || lt_f) && s.digit_a != s.digit_b) begin
                    gt_f <= s.digit_a > s.digit_b;
                    lt_f <= s.digit_a < s.digit_b;
                end
                if (last) res_valid <= 1'b1;
            end
        end
    end
    assign s.ready        = state == RUN;
    assign s.busy         = state == RUN;
    assign s.done         = state == DONE;
    assign s.result_valid = res_valid;
    assign s.gt           = res_valid & gt_f;
    assign s.lt           = res_valid & lt_f;
    assign s.eq           = res_valid & ~gt_f & ~lt_f;
    assign s.count        = count;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: directed vectors with hand-computed results for serial_compare_ctrl.
module tb_serial_compare_ctrl;
    localparam int DIGITS = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc;
    serial_compare_ctrl_if #(.DIGITS(DIGITS)) ifc ();
    serial_compare_ctrl #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .s(ifc));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {ifc.ready, ifc.busy, ifc.done, ifc.result_valid, ifc.gt, ifc.lt, ifc.eq};
    endfunction

    // Starts in the current IDLE cycle, streams a/b, returns the cycle (start = 0) of done.
    task automatic compare(input logic [7:0] a, input logic [7:0] b, input bit alt, output int n);
        int k;
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        chk("start_clears", {25'd0, outs()}, 32'b1100000);
        n = 1;
        k = DIGITS - 1;
        while (!ifc.done && n < 40) begin
            ifc.valid = (k >= 0) && (!alt || n[0]);
            if (k >= 0) begin
                ifc.digit_a = a[2*k +: 2];
                ifc.digit_b = b[2*k +: 2];
            end
            if (ifc.valid && ifc.ready) k--;
            step();
            n++;
        end
        ifc.valid = 1'b0;
    endtask

    initial begin
        ifc.start = 1'b0;
        ifc.abort = 1'b0;
        ifc.valid = 1'b0;
        ifc.digit_a = 2'd0;
        ifc.digit_b = 2'd0;
        step();
        step();
        chk("reset_outs", {25'd0, outs()}, 0);
        chk("reset_count", ifc.count, 0);
        rst = 1'b0;
        step();
        compare(8'b10_01_11_00, 8'b10_01_10_11, 1'b0, cyc);
        chk("gt_cycle", cyc, 5);
        chk("gt_outs", {25'd0, outs()}, 32'b0011100);
        chk("gt_count", ifc.count, 4);
        step();
        chk("gt_hold", {25'd0, outs()}, 32'b0001100);
        ifc.abort = 1'b1;
        step();
        ifc.abort = 1'b0;
        chk("idle_abort_noeffect", {25'd0, outs()}, 32'b0001100);
        compare(8'b00_11_01_10, 8'b01_00_00_00, 1'b0, cyc);
        chk("lt_cycle", cyc, 5);
        chk("lt_outs", {25'd0, outs()}, 32'b0011010);
        chk("lt_count", ifc.count, 4);
        step();
        compare(8'b11_10_01_00, 8'b11_10_01_00, 1'b1, cyc);
        chk("eq_cycle", cyc, 8);
        chk("eq_outs", {25'd0, outs()}, 32'b0011001);
        chk("eq_count", ifc.count, 4);
        step();
        compare(8'b00_00_00_01, 8'b00_00_00_00, 1'b0, cyc);
        chk("b2b_cycle", cyc, 5);
        chk("b2b_outs", {25'd0, outs()}, 32'b0011100);
        step();
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        ifc.valid = 1'b1;
        ifc.digit_a = 2'd1;
        ifc.digit_b = 2'd2;
        step();
        step();
        chk("abort_pre_count", ifc.count, 2);
        ifc.abort = 1'b1;
        step();
        ifc.abort = 1'b0;
        ifc.valid = 1'b0;
        chk("abort_outs", {25'd0, outs()}, 0);
        chk("abort_count", ifc.count, 0);
        step();
        chk("abort_no_done", {25'd0, outs()}, 0);
        compare(8'b01_01_01_01, 8'b01_01_01_10, 1'b0, cyc);
        chk("post_abort_cycle", cyc, 5);
        chk("post_abort_outs", {25'd0, outs()}, 32'b0011010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_done_outs", {25'd0, outs()}, 0);
        chk("rst_done_count", ifc.count, 0);
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        ifc.valid = 1'b1;
        ifc.digit_a = 2'd3;
        ifc.digit_b = 2'd3;
        step();
        step();
        ifc.valid = 1'b0;
        ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        chk("run_start_ignored", ifc.count, 2);
        chk("run_start_busy", ifc.busy, 1);
        rst = 1'b1;
        ifc.valid = 1'b1;
        step();
        rst = 1'b0;
        ifc.valid = 1'b0;
        chk("rst_run_outs", {25'd0, outs()}, 0);
        chk("rst_run_count", ifc.count, 0);
        compare(8'b11_00_00_00, 8'b10_11_11_11, 1'b0, cyc);
        chk("post_rst_cycle", cyc, 5);
        chk("post_rst_outs", {25'd0, outs()}, 32'b0011100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of 2-bit digits per operand (legal 2..16); operand width = 2*DIGITS.
REQ-002 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_Reset  input  1  reset, synchronous and active-high.
REQ-004 i_Start  input  1  start a comparison; sampled only in IDLE.
REQ-005 i_Abort  input  1  abandon the current comparison; sampled in RUN and DONE.
REQ-006 i_Valid  input  1  digit pair on i_DigitA/i_DigitB is valid.
REQ-007 i_DigitA  input  2  current digit of operand A, most significant digit first.
REQ-008 i_DigitB  input  2  current digit of operand B, most significant digit first.
REQ-009 o_Ready  output  1  controller accepts a digit pair this cycle.
REQ-010 o_Busy  output  1  comparison in progress (RUN).
REQ-011 o_Done  output  1  one-cycle pulse: result just became final.
REQ-012 o_ResultValid  output  1  o_GT/o_LT/o_EQ hold a final result.
REQ-013 o_GT / o_LT / o_EQ  output  1 each  A>B / A<B / A=B for the last completed comparison.
REQ-014 o_Count  output  clog2(DIGITS+1)  number of digit pairs accepted in the current comparison.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; the encoding is free.
REQ-016 In IDLE, i_Start=1 SHALL move to RUN next cycle, clear o_Count, clear the decided/GT/LT flags and deassert o_ResultValid, o_GT, o_LT and o_EQ.
REQ-017 In RUN, o_Ready and o_Busy SHALL be 1; in IDLE and DONE both SHALL be 0.
REQ-018 A digit pair SHALL be accepted only on a cycle with i_Valid=1 and o_Ready=1; each accepted pair increments o_Count by 1.
REQ-019 i_Valid=0 in RUN SHALL stall: state, o_Count and flags unchanged, with no timeout.
REQ-020 First unequal accepted pair SHALL decide: GT if DigitA>DigitB, otherwise LT; decided flag set.
REQ-021 Once decided, later pairs SHALL still be accepted and counted, but SHALL NOT change the GT/LT flags.
REQ-022 When the DIGITS-th pair is accepted, the FSM SHALL enter DONE on the next cycle.
REQ-023 In DONE (exactly one cycle), o_Done=1, o_ResultValid=1; o_GT/o_LT from flags, o_EQ=1 if and only if no pair was unequal; then return to IDLE.
REQ-024 o_GT, o_LT, o_EQ and o_ResultValid SHALL hold their values in IDLE until the next accepted i_Start or reset.
REQ-025 At all times, at most one of o_GT/o_LT/o_EQ SHALL be 1; all three are 0 whenever o_ResultValid=0.
REQ-026 Latency: with i_Valid held at 1, i_Start at cycle 0 gives pairs accepted at cycles 1..DIGITS and o_Done at cycle DIGITS+1.
REQ-027 i_Start in RUN or DONE SHALL be ignored; back-to-back: i_Start in the IDLE cycle after DONE SHALL be honoured.
REQ-028 i_Abort in RUN or DONE SHALL return to IDLE next cycle with o_Done=0, o_ResultValid=0, all results 0, o_Count=0; i_Abort has priority over digit acceptance.
REQ-029 i_Abort in IDLE SHALL have no effect.
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs.

Reset
REQ-031 i_Reset=1 SHALL, at the next edge, force IDLE with o_Count=0 and every output 0, overriding all other inputs, including mid-RUN and during DONE.
REQ-032 The first i_Start after reset deassertion SHALL be honoured.

Verification (DIGITS=4, i_Valid=1 continuously unless stated)
REQ-033 A=10_01_11_00, B=10_01_10_11 -> o_Done at cycle 5, o_GT=1, o_LT=0, o_EQ=0, o_Count=4.
REQ-034 A=00_11_01_10, B=01_00_00_00 -> decided LT at pair 1, all 4 pairs consumed, o_LT=1 at cycle 5.
REQ-035 A=B=11_10_01_00 with i_Valid low on alternate cycles -> 4 accepts, o_Done at cycle 8, o_EQ=1.
REQ-036 i_Abort asserted after 2 pairs -> IDLE next cycle, no o_Done, all results 0; a new i_Start then compares correctly.
REQ-037 i_Reset asserted in DONE and separately in RUN -> all outputs 0 next cycle, and i_Start during RUN is ignored (o_Count not cleared).
REQ-038 Back-to-back: i_Start in the IDLE cycle after DONE -> previous result is cleared and the second comparison completes with correct latency.
